// File: rtl/glitch_trigger_seq.sv
// Re-armable smartcard glitch trigger: counts N qualifying sc_io edges, waits D
// cycles, then emits K pulses of W cycles separated by G-cycle gaps.
module glitch_trigger_seq #(
   parameter int unsigned CTR_W       = 32,
   parameter int unsigned PW_W        = 16,
   parameter int unsigned PC_W        = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             sc_clk,
   input  logic             sc_reset,
   input  logic             sc_io,
   input  logic             arm,
   input  logic             abort,
   input  logic             io_falling,
   input  logic [CTR_W-1:0] cfg_io_target,
   input  logic [CTR_W-1:0] cfg_delay,
   input  logic [PW_W-1:0]  cfg_width,
   input  logic [PW_W-1:0]  cfg_gap,
   input  logic [PC_W-1:0]  cfg_count,
   output logic             trigger,
   output logic             armed,
   output logic             busy,
   output logic             done,
   output logic             led_out,
   output logic             led_out_2
);

   localparam int unsigned      SS      = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);
   localparam logic [PW_W-1:0]  PW_ONE  = PW_W'(1);
   localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);

   typedef enum logic [2:0] {
      IDLE,
      ARM_WAIT,
      DELAY,
      PULSE,
      GAP,
      DONE
   } state_e;

   // Reset asserts asynchronously but releases on a clock edge.
   logic [1:0] rst_sync_q, rst_sync_d;
   logic       rst_n;

   always_comb begin
      rst_sync_d = {rst_sync_q[0], 1'b1};
   end

   always_ff @(posedge sc_clk or negedge sc_reset) begin
      if (!sc_reset) rst_sync_q <= '0;
      else           rst_sync_q <= rst_sync_d;
   end

   assign rst_n = rst_sync_q[1];

   // Rising and falling edges are registered separately so the polarity
   // latched at arm applies to the very first edge seen after it.
   logic [SS-1:0] sync_q, sync_d;
   logic          io_prev_q, io_prev_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;
   logic          arm_hist_q, arm_hist_d;

   always_comb begin
      sync_d     = {sync_q[SS-2:0], sc_io};
      io_prev_d  = sync_q[SS-1];
      rise_d     = sync_q[SS-1] & ~io_prev_q;
      fall_d     = ~sync_q[SS-1] & io_prev_q;
      arm_hist_d = arm;
   end

   always_ff @(posedge sc_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= '0;
         io_prev_q  <= 1'b0;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
         arm_hist_q <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         io_prev_q  <= io_prev_d;
         rise_q     <= rise_d;
         fall_q     <= fall_d;
         arm_hist_q <= arm_hist_d;
      end
   end

   state_e           state_q, state_d;
   logic             pol_q, pol_d;
   logic [CTR_W-1:0] n_q, n_d;
   logic [CTR_W-1:0] dly_tgt_q, dly_tgt_d;
   logic [PW_W-1:0]  w_q, w_d;
   logic [PW_W-1:0]  g_q, g_d;
   logic [PC_W-1:0]  k_q, k_d;
   logic [CTR_W-1:0] edge_cnt_q, edge_cnt_d;
   logic [CTR_W-1:0] dly_cnt_q, dly_cnt_d;
   logic [PW_W-1:0]  pw_cnt_q, pw_cnt_d;
   logic [PC_W-1:0]  pulse_cnt_q, pulse_cnt_d;
   logic             trigger_q, trigger_d;
   logic             armed_q, armed_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             led2_q, led2_d;

   logic             edge_seen;
   logic             arm_rise;
   logic [CTR_W-1:0] dly_nxt;
   logic [PW_W-1:0]  pw_nxt;

   assign edge_seen = pol_q ? fall_q : rise_q;
   assign arm_rise  = arm & ~arm_hist_q;
   assign dly_nxt   = dly_cnt_q + CTR_ONE;
   assign pw_nxt    = pw_cnt_q + PW_ONE;

   always_comb begin
      state_d     = state_q;
      pol_d       = pol_q;
      n_d         = n_q;
      dly_tgt_d   = dly_tgt_q;
      w_d         = w_q;
      g_d         = g_q;
      k_d         = k_q;
      edge_cnt_d  = edge_cnt_q;
      dly_cnt_d   = dly_cnt_q;
      pw_cnt_d    = pw_cnt_q;
      pulse_cnt_d = pulse_cnt_q;

      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (arm_rise) begin
                  state_d    = ARM_WAIT;
                  pol_d      = io_falling;
                  n_d        = (cfg_io_target == '0) ? CTR_ONE : cfg_io_target;
                  dly_tgt_d  = cfg_delay;
                  w_d        = (cfg_width == '0) ? PW_ONE : cfg_width;
                  g_d        = (cfg_gap == '0) ? PW_ONE : cfg_gap;
                  k_d        = (cfg_count == '0) ? PC_ONE : cfg_count;
                  edge_cnt_d = '0;
               end
            end
            ARM_WAIT: begin
               if (edge_seen) begin
                  edge_cnt_d = edge_cnt_q + CTR_ONE;
                  if (edge_cnt_q == n_q - CTR_ONE) begin
                     dly_cnt_d = '0;
                     // A zero delay skips DELAY so the pulse starts one cycle after the edge.
                     if (dly_tgt_q == '0) begin
                        state_d     = PULSE;
                        pw_cnt_d    = '0;
                        pulse_cnt_d = PC_ONE;
                     end else begin
                        state_d = DELAY;
                     end
                  end
               end
            end
            DELAY: begin
               if (dly_nxt == dly_tgt_q) begin
                  state_d     = PULSE;
                  pw_cnt_d    = '0;
                  pulse_cnt_d = PC_ONE;
               end else begin
                  dly_cnt_d = dly_nxt;
               end
            end
            PULSE: begin
               if (pw_nxt == w_q) begin
                  pw_cnt_d = '0;
                  state_d  = (pulse_cnt_q == k_q) ? DONE : GAP;
               end else begin
                  pw_cnt_d = pw_nxt;
               end
            end
            GAP: begin
               if (pw_nxt == g_q) begin
                  state_d     = PULSE;
                  pw_cnt_d    = '0;
                  pulse_cnt_d = pulse_cnt_q + PC_ONE;
               end else begin
                  pw_cnt_d = pw_nxt;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      trigger_d = (state_d == PULSE);
      armed_d   = (state_d == ARM_WAIT);
      busy_d    = (state_d == DELAY) || (state_d == PULSE) || (state_d == GAP);
      done_d    = (state_d == DONE);
      led2_d    = busy_d || done_d;
   end

   always_ff @(posedge sc_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pol_q       <= 1'b0;
         n_q         <= '0;
         dly_tgt_q   <= '0;
         w_q         <= '0;
         g_q         <= '0;
         k_q         <= '0;
         edge_cnt_q  <= '0;
         dly_cnt_q   <= '0;
         pw_cnt_q    <= '0;
         pulse_cnt_q <= '0;
         trigger_q   <= 1'b0;
         armed_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         led2_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pol_q       <= pol_d;
         n_q         <= n_d;
         dly_tgt_q   <= dly_tgt_d;
         w_q         <= w_d;
         g_q         <= g_d;
         k_q         <= k_d;
         edge_cnt_q  <= edge_cnt_d;
         dly_cnt_q   <= dly_cnt_d;
         pw_cnt_q    <= pw_cnt_d;
         pulse_cnt_q <= pulse_cnt_d;
         trigger_q   <= trigger_d;
         armed_q     <= armed_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         led2_q      <= led2_d;
      end
   end

   assign trigger   = trigger_q;
   assign led_out   = trigger_q;
   assign armed     = armed_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign led_out_2 = led2_q;

endmodule

// File: tb/tb_glitch_trigger_seq.sv
// Bench for glitch_trigger_seq: schedule-based reference model checked every
// cycle, plus directed scenarios with hand-computed timing expectations.
module tb_glitch_trigger_seq;

   localparam int S  = 2;
   localparam int HN = S + 3;

   logic        sc_clk = 1'b0;
   logic        sc_reset = 1'b1;
   logic        sc_io = 1'b0;
   logic        arm = 1'b0;
   logic        abort = 1'b0;
   logic        io_falling = 1'b0;
   logic [31:0] cfg_io_target = '0;
   logic [31:0] cfg_delay = '0;
   logic [15:0] cfg_width = '0;
   logic [15:0] cfg_gap = '0;
   logic [7:0]  cfg_count = '0;
   logic        trigger, armed, busy, done, led_out, led_out_2;

   glitch_trigger_seq #(
      .CTR_W(32),
      .PW_W(16),
      .PC_W(8),
      .SYNC_STAGES(S)
   ) dut (
      .sc_clk(sc_clk),
      .sc_reset(sc_reset),
      .sc_io(sc_io),
      .arm(arm),
      .abort(abort),
      .io_falling(io_falling),
      .cfg_io_target(cfg_io_target),
      .cfg_delay(cfg_delay),
      .cfg_width(cfg_width),
      .cfg_gap(cfg_gap),
      .cfg_count(cfg_count),
      .trigger(trigger),
      .armed(armed),
      .busy(busy),
      .done(done),
      .led_out(led_out),
      .led_out_2(led_out_2)
   );

   always #5 sc_clk = ~sc_clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge sc_clk) cyc++;

   // Reference model: a run is a schedule. The Nth qualifying edge at cycle te
   // puts the first pulse at te+D; the train then follows from W, G, K arithmetic.
   bit hist [0:HN-1];
   int mp = 0;
   int rel = 0;
   bit m_arm_prev, m_wait, m_fired, m_pol;
   int m_n, m_d, m_w, m_g, m_k, m_cnt, m_fire, m_len;
   bit e_trig, e_armed, e_busy, e_done, e_led2;
   bit ar, ev, quiet;

   task automatic mreset();
      for (int k = 0; k < HN; k++) hist[k] = 1'b0;
      m_arm_prev = 1'b0;
      m_wait     = 1'b0;
      m_fired    = 1'b0;
      m_cnt      = 0;
      e_trig     = 1'b0;
      e_armed    = 1'b0;
      e_busy     = 1'b0;
      e_done     = 1'b0;
      e_led2     = 1'b0;
   endtask

   always @(posedge sc_clk or negedge sc_reset) begin
      if (!sc_reset) begin
         rel = 0;
         mreset();
      end else begin
         mp++;
         for (int k = HN - 1; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = sc_io;
         if (rel < 2) begin
            rel++;
            mreset();
         end else begin
            ar = arm && !m_arm_prev;
            m_arm_prev = arm;
            // an sc_io change sampled at cycle c is acted on at cycle c+S+2
            ev = m_pol ? (hist[S+2] && !hist[S+1]) : (!hist[S+2] && hist[S+1]);
            quiet = (!m_wait && !m_fired) || (m_fired && (mp - 1 >= m_fire + m_len));
            if (abort) begin
               m_wait  = 1'b0;
               m_fired = 1'b0;
            end else if (ar && quiet) begin
               m_wait  = 1'b1;
               m_fired = 1'b0;
               m_cnt   = 0;
               m_pol   = io_falling;
               m_n     = (cfg_io_target == 0) ? 1 : int'(cfg_io_target);
               m_d     = int'(cfg_delay);
               m_w     = (cfg_width == 0) ? 1 : int'(cfg_width);
               m_g     = (cfg_gap == 0) ? 1 : int'(cfg_gap);
               m_k     = (cfg_count == 0) ? 1 : int'(cfg_count);
            end else if (m_wait && ev) begin
               m_cnt++;
               if (m_cnt == m_n) begin
                  m_wait  = 1'b0;
                  m_fired = 1'b1;
                  m_fire  = mp + m_d;
                  m_len   = m_k * m_w + (m_k - 1) * m_g;
               end
            end
            e_armed = m_wait;
            e_led2  = m_fired;
            if (m_fired) begin
               e_busy = (mp < m_fire + m_len);
               e_done = !e_busy;
               e_trig = e_busy && (mp >= m_fire) && (((mp - m_fire) % (m_w + m_g)) < m_w);
            end else begin
               e_busy = 1'b0;
               e_done = 1'b0;
               e_trig = 1'b0;
            end
         end
      end
   end

   always @(negedge sc_clk) begin
      chk("trigger", int'(trigger), int'(e_trig));
      chk("led_out", int'(led_out), int'(e_trig));
      chk("armed", int'(armed), int'(e_armed));
      chk("busy", int'(busy), int'(e_busy));
      chk("done", int'(done), int'(e_done));
      chk("led_out_2", int'(led_out_2), int'(e_led2));
   end

   // Per-scenario observations used by the literal checks.
   int st_first, st_last, st_hi, st_busy, st_l2first;
   bit st_seen, st_l2_seen, st_l2_prev;

   always @(negedge sc_clk) begin
      if (trigger) begin
         if (!st_seen) begin
            st_seen  = 1'b1;
            st_first = cyc;
         end
         st_last = cyc;
         st_hi++;
      end
      if (busy) st_busy++;
      if (led_out_2 && !st_l2_prev && !st_l2_seen) begin
         st_l2_seen = 1'b1;
         st_l2first = cyc;
      end
      st_l2_prev = led_out_2;
   end

   task automatic clear_stats();
      st_seen    = 1'b0;
      st_l2_seen = 1'b0;
      st_first   = -1;
      st_last    = -1;
      st_l2first = -1;
      st_hi      = 0;
      st_busy    = 0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge sc_clk);
   endtask

   task automatic do_arm(input int n, input int d, input int w, input int g, input int k, input bit pol);
      cfg_io_target = n;
      cfg_delay     = d;
      cfg_width     = 16'(w);
      cfg_gap       = 16'(g);
      cfg_count     = 8'(k);
      io_falling    = pol;
      arm           = 1'b1;
      tick(1);
      arm           = 1'b0;
      cfg_io_target = 32'd5;
      cfg_delay     = 32'd77;
      cfg_width     = 16'd9;
      cfg_gap       = 16'd3;
      cfg_count     = 8'd6;
      io_falling    = ~pol;
      tick(1);
   endtask

   task automatic io_pulse(output int rise_cyc);
      sc_io    = 1'b1;
      rise_cyc = cyc;
      tick(2);
      sc_io    = 1'b0;
      tick(2);
   endtask

   task automatic wait_trig(input bit val, input int lim, input string nm);
      for (int i = 0; i < lim && trigger !== val; i++) tick(1);
      chk(nm, int'(trigger), int'(val));
   endtask

   initial begin
      #2_000_000;
      n_bad++;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      int r, r1, r2;
      clear_stats();
      #1 sc_reset = 1'b0;
      tick(3);
      chk("reset_trigger", int'(trigger), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_led2", int'(led_out_2), 0);
      sc_reset = 1'b1;
      tick(5);

      // N=3 rising, D=0, W=1, K=1; the 4th edge must be ignored
      clear_stats();
      do_arm(3, 0, 1, 1, 1, 1'b0);
      chk("t1_armed", int'(armed), 1);
      io_pulse(r1);
      io_pulse(r1);
      io_pulse(r);
      io_pulse(r1);
      tick(10);
      chk("t1_latency", st_first - r, S + 2);
      chk("t1_width", st_hi, 1);
      chk("t1_done", int'(done), 1);

      // N=720, D=13255, W=4
      clear_stats();
      do_arm(720, 13255, 4, 1, 1, 1'b0);
      for (int i = 0; i < 720; i++) io_pulse(r);
      tick(13270);
      chk("t2_first", st_first - r, 13259);
      chk("t2_width", st_hi, 4);
      chk("t2_led2", st_l2first - r, 4);
      chk("t2_done", int'(done), 1);

      // K=3, W=2, G=5: 2/5/2/5/2
      clear_stats();
      do_arm(1, 0, 2, 5, 3, 1'b0);
      io_pulse(r);
      tick(30);
      chk("t3_high", st_hi, 6);
      chk("t3_span", st_last - st_first, 15);
      chk("t3_busy", st_busy, 16);
      chk("t3_done", int'(done), 1);

      // falling polarity, N=2
      clear_stats();
      do_arm(2, 0, 1, 1, 1, 1'b1);
      io_pulse(r1);
      io_pulse(r2);
      tick(10);
      chk("t4_latency", st_first - (r2 + 2), S + 2);
      chk("t4_width", st_hi, 1);

      // abort mid second pulse of K=4, then a fresh run
      clear_stats();
      do_arm(1, 0, 3, 2, 4, 1'b0);
      io_pulse(r);
      wait_trig(1'b1, 10, "t5_p1_rise");
      wait_trig(1'b0, 10, "t5_p1_fall");
      wait_trig(1'b1, 10, "t5_p2_rise");
      tick(1);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      chk("t5_abort_trig", int'(trigger), 0);
      chk("t5_abort_done", int'(done), 0);
      chk("t5_abort_busy", int'(busy), 0);
      chk("t5_abort_armed", int'(armed), 0);
      chk("t5_abort_hi", st_hi, 5);
      tick(3);
      clear_stats();
      do_arm(2, 3, 2, 1, 2, 1'b0);
      io_pulse(r1);
      io_pulse(r2);
      tick(20);
      chk("t5_rerun_first", st_first - r2, S + 2 + 3);
      chk("t5_rerun_high", st_hi, 4);
      chk("t5_rerun_done", int'(done), 1);

      // asynchronous reset during DELAY
      clear_stats();
      do_arm(1, 50, 1, 1, 1, 1'b0);
      io_pulse(r);
      tick(5);
      chk("t6_in_delay", int'(busy), 1);
      #2 sc_reset = 1'b0;
      #1;
      chk("t6_async_trig", int'(trigger), 0);
      chk("t6_async_busy", int'(busy), 0);
      chk("t6_async_led2", int'(led_out_2), 0);
      chk("t6_async_done", int'(done), 0);
      tick(3);
      sc_reset = 1'b1;
      tick(2);
      clear_stats();
      for (int i = 0; i < 3; i++) io_pulse(r);
      tick(60);
      chk("t6_no_trig", st_hi, 0);
      chk("t6_no_led2", int'(st_l2_seen), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/glitch_trigger_seq.md
Name: glitch_trigger_seq

Overview:
- Parametrised, re-armable successor to the single-shot smartcard glitch trigger.
- Counts N qualifying edges on the card I/O line (selectable polarity), waits D card-clock cycles, then emits a programmable train of K pulses of W cycles each, separated by G-cycle gaps.
- Runtime configuration is latched at arm, so the host can sweep offsets without resynthesis.
- Sits between the smartcard tap and the glitch driver; led_out and led_out_2 keep their status meaning.

Parameters:
- CTR_W, 32: width of the I/O-edge and delay counters and of cfg_io_target / cfg_delay.
- PW_W, 16: width of cfg_width and cfg_gap.
- PC_W, 8: width of cfg_count.
- SYNC_STAGES, 2: synchroniser flops on sc_io (min 2).

Ports:
- sc_clk, in, 1: card clock; the only clock.
- sc_reset, in, 1: asynchronous, active-low reset.
- sc_io, in, 1: card I/O line; asynchronous to sc_clk.
- arm, in, 1: level; a rising edge in IDLE or DONE starts a run.
- abort, in, 1: synchronous; forces IDLE from any state.
- io_falling, in, 1: 0 = count 0->1 edges, 1 = count 1->0 edges; latched at arm.
- cfg_io_target, in, CTR_W: N, the edge index to fire on; 0 is treated as 1.
- cfg_delay, in, CTR_W: D, cycles from the Nth edge to the first pulse.
- cfg_width, in, PW_W: W, pulse high time in cycles; 0 is treated as 1.
- cfg_gap, in, PW_W: G, low time between pulses in cycles; 0 is treated as 1.
- cfg_count, in, PC_W: K, number of pulses; 0 is treated as 1.
- trigger, out, 1: glitch pulse output, registered.
- armed, out, 1: high in ARM_WAIT.
- busy, out, 1: high in DELAY, PULSE or GAP.
- done, out, 1: high in DONE.
- led_out, out, 1: equals trigger.
- led_out_2, out, 1: high from the Nth edge until exit of DONE, i.e. in DELAY, PULSE, GAP or DONE.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, synchroniser flops 0, arm-edge history 0. Reset is asynchronous assert, synchronous release.
- sc_io passes through SYNC_STAGES flops. The edge detector compares the last two synced samples. edge_q is a registered 1-cycle pulse.
- States: IDLE, ARM_WAIT, DELAY, PULSE, GAP, DONE.
- IDLE/DONE -> ARM_WAIT on arm 0->1, sampled in sc_clk. On that cycle all cfg_* inputs and io_falling are latched and the edge counter is cleared. Arm edges in other states are ignored.
- ARM_WAIT: each edge_q increments the edge counter. When edge_q occurs with counter == N-1 (the Nth edge), go to DELAY and clear the delay counter. Edges before arm are never counted.
- DELAY: the delay counter increments each cycle. Go to PULSE when counter == D, so with the Nth edge_q at cycle t, trigger first rises at cycle t+1+D (D=0 gives t+1). sc_io edges are ignored from DELAY onward.
- PULSE: trigger=1 for exactly W cycles, then:
  - if pulses issued < K, go to GAP;
  - otherwise go to DONE.
- GAP: trigger=0 for exactly G cycles, then go to PULSE.
- DONE: trigger=0, done=1. Remains until a new arm rising edge (or abort, which goes to IDLE).
- abort: highest priority after reset. Next state is IDLE and trigger drops on the next edge, including mid-pulse. Abort and arm in the same cycle: abort wins.
- Counters compare with ==, never wrap. The latched targets fit CTR_W by construction.
- Config inputs changing after arm have no effect on the current run.

Test Plan:
- N=3, D=0, W=1, K=1, rising; arm, then 4 sc_io rising edges -> exactly one trigger pulse 1 cycle wide, rising SYNC_STAGES+2 cycles after the 3rd sc_io rise (synchroniser + edge_q + DELAY); 4th edge ignored; done=1 afterwards.
- N=720, D=13255, W=4 -> trigger high 4 cycles starting 13256 cycles after edge_q of the 720th edge; led_out_2 high from the cycle after that edge_q.
- K=3, W=2, G=5 -> trigger pattern 2 high / 5 low / 2 high / 5 low / 2 high, then DONE; busy spans the whole train.
- io_falling=1, N=2 -> rising edges do not count; the 2nd falling edge fires the trigger.
- abort asserted during the 2nd pulse of K=4 -> trigger 0 the next cycle, state IDLE, done=0; re-arm with new cfg gives a full fresh run.
- Reset asserted mid-DELAY, asynchronously between clock edges -> all outputs 0 immediately; sc_io edges are ignored until arm.
